// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, fetches one word at a
//               time over req/gnt/rvalid and hands it to the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] PC,
    output logic [31:0] inst,
    output logic        instValid,
    input  logic        decodeReady,
    input  logic        takeBranch,
    input  logic        PCsrc,
    input  logic        PCsrc2,
    input  logic [31:0] extendOffset,
    input  logic [31:0] jalrTarget,
    output logic        fetchFault,
    output logic [31:0] instCount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] count_q, count_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic [31:0] w_next_pc;
    logic        w_misaligned;

    // jalr outranks jal; jal and a taken branch share the same target formula
    always_comb begin
        w_next_pc = pc_q + 32'd4;
        if (PCsrc2) begin
            w_next_pc = jalrTarget & ~32'h1;
        end else if (PCsrc || takeBranch) begin
            w_next_pc = pc_q + extendOffset;
        end
        w_misaligned = (w_next_pc[1:0] != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        count_d = count_q;
        valid_d = valid_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imemGnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imemRvalid) begin
                    inst_d  = imemRdata;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (decodeReady) begin
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                    pc_d    = w_next_pc;
                    if (w_misaligned) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            count_q <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            count_q <= count_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign imemReq    = (state_q == S_REQ);
    assign imemAddr   = pc_q;
    assign PC         = pc_q;
    assign inst       = inst_q;
    assign instValid  = valid_q;
    assign fetchFault = fault_q;
    assign instCount  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: memory responder,
//               transaction-level PC/count/fault model, directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt = 1'b0;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = 32'd0;
    logic [31:0] PC;
    logic [31:0] inst;
    logic        instValid;
    logic        decodeReady = 1'b0;
    logic        takeBranch = 1'b0;
    logic        PCsrc = 1'b0;
    logic        PCsrc2 = 1'b0;
    logic [31:0] extendOffset = 32'd0;
    logic [31:0] jalrTarget = 32'd0;
    logic        fetchFault;
    logic [31:0] instCount;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemGnt     (imemGnt),
        .imemRvalid  (imemRvalid),
        .imemRdata   (imemRdata),
        .PC          (PC),
        .inst        (inst),
        .instValid   (instValid),
        .decodeReady (decodeReady),
        .takeBranch  (takeBranch),
        .PCsrc       (PCsrc),
        .PCsrc2      (PCsrc2),
        .extendOffset(extendOffset),
        .jalrTarget  (jalrTarget),
        .fetchFault  (fetchFault),
        .instCount   (instCount)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Address-dependent contents so a wrong fetch address shows up as wrong data
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + (a << 12);
    endfunction

    // Memory responder: grants after stall_cfg request cycles, answers rv_lat cycles later
    int          stall_cfg = 0;
    int          rv_lat = 0;
    int          req_cycles = 0;
    int          lat = 0;
    logic        will = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'd0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            imemGnt = 1'b0; imemRvalid = 1'b0;
            will = 1'b0; pend = 1'b0; req_cycles = 0;
        end else begin
            imemRvalid = 1'b0;
            if (will) begin
                pend = 1'b1; lat = rv_lat; will = 1'b0;
            end
            if (pend) begin
                if (lat == 0) begin
                    imemRvalid = 1'b1; imemRdata = mem_word(paddr); pend = 1'b0;
                end else begin
                    lat--;
                end
            end
            if (imemReq) begin
                if (req_cycles < stall_cfg) begin
                    imemGnt = 1'b0; req_cycles++;
                end else begin
                    imemGnt = 1'b1; will = 1'b1; paddr = imemAddr; req_cycles = 0;
                end
            end else begin
                imemGnt = 1'b0;
            end
        end
    end

    // Architectural model: PC, retired count and sticky fault, advanced per accept
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_cnt = 32'd0;
    logic        m_fault = 1'b0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            m_pc = RESET_PC; m_cnt = 32'd0; m_fault = 1'b0;
        end else if (prev_valid && decodeReady) begin
            if (PCsrc2)          m_pc = {jalrTarget[31:1], 1'b0};
            else if (PCsrc)      m_pc = m_pc + extendOffset;
            else if (takeBranch) m_pc = m_pc + extendOffset;
            else                 m_pc = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
            if (m_pc[1:0] != 2'b00) m_fault = 1'b1;
        end
        prev_valid = instValid;
        chk("model_pc", PC, m_pc);
        chk("model_count", instCount, m_cnt);
        chk("model_fault", {31'd0, fetchFault}, {31'd0, m_fault});
        if (instValid) chk("model_inst", inst, mem_word(m_pc));
        if (imemReq)   chk("model_addr", imemAddr, m_pc);
        if (rst || m_fault) begin
            chk("quiet_req", {31'd0, imemReq}, 32'd0);
            chk("quiet_valid", {31'd0, instValid}, 32'd0);
        end
    end

    task automatic wait_valid(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instValid) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL %s: instValid timeout, actual 0 required 1", name);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 60; i++) begin
            if (imemReq) return;
            @(negedge clk);
        end
        n_cmp++; n_bad++;
        $display("FAIL %s: imemReq timeout, actual 0 required 1", name);
    endtask

    task automatic accept_with(input logic br, input logic jal, input logic jalr,
                               input logic [31:0] off, input logic [31:0] tgt);
        takeBranch = br; PCsrc = jal; PCsrc2 = jalr;
        extendOffset = off; jalrTarget = tgt; decodeReady = 1'b1;
        @(negedge clk);
        takeBranch = 1'b0; PCsrc = 1'b0; PCsrc2 = 1'b0; decodeReady = 1'b0;
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", {31'd0, instValid}, 32'd0);
            chk("rst_req", {31'd0, imemReq}, 32'd0);
            chk("rst_pc", PC, 32'd0);
            chk("rst_inst", inst, 32'd0);
            chk("rst_count", instCount, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", {31'd0, imemReq}, 32'd1);
        chk("first_addr", imemAddr, 32'd0);

        // sequential stream
        decodeReady = 1'b1;
        wait_valid("v0");
        chk("seq_pc0", PC, 32'd0);
        chk("seq_inst0", inst, 32'h0050_0093);
        wait_valid("v4");
        chk("seq_pc4", PC, 32'd4);
        stall_cfg = 4;
        @(negedge clk);
        decodeReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_req", {31'd0, imemReq}, 32'd1);
            chk("stall_addr", imemAddr, 32'd8);
        end
        wait_valid("v8");
        stall_cfg = 0;
        chk("seq_pc8", PC, 32'd8);
        chk("seq_count2", instCount, 32'd2);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, instValid}, 32'd1);
            chk("bp_pc", PC, 32'd8);
            chk("bp_inst", inst, 32'h0050_8093);
            chk("bp_count", instCount, 32'd2);
        end

        // jal backwards, then branch, then jal+branch together
        accept_with(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0);
        chk("jal_count3", instCount, 32'd3);
        wait_req("jal");
        chk("jal_addr", imemAddr, 32'd0);
        wait_valid("vbr");
        accept_with(1'b1, 1'b0, 1'b0, 32'd16, 32'd0);
        wait_req("br");
        chk("br_addr", imemAddr, 32'h10);
        wait_valid("vboth");
        accept_with(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        wait_req("both");
        chk("both_addr", imemAddr, 32'h30);

        // jalr outranks jal; bit0 cleared, no fault
        wait_valid("vjalr");
        accept_with(1'b0, 1'b1, 1'b1, 32'd4, 32'h101);
        chk("jalr_nofault", {31'd0, fetchFault}, 32'd0);
        wait_req("jalr");
        chk("jalr_addr", imemAddr, 32'h100);
        wait_valid("v100");
        chk("jalr_inst", inst, 32'h0060_0093);
        accept_with(1'b0, 1'b0, 1'b1, 32'd0, 32'h102);
        chk("fault_set", {31'd0, fetchFault}, 32'd1);
        chk("fault_pc", PC, 32'h102);
        repeat (10) begin
            @(negedge clk);
            chk("fault_req", {31'd0, imemReq}, 32'd0);
            chk("fault_valid", {31'd0, instValid}, 32'd0);
            chk("fault_sticky", {31'd0, fetchFault}, 32'd1);
        end

        // reset in WAIT
        rst = 1'b1;
        @(negedge clk);
        chk("rstf_fault", {31'd0, fetchFault}, 32'd0);
        chk("rstf_pc", PC, 32'd0);
        rst = 1'b0;
        decodeReady = 1'b1;
        wait_valid("r0");
        chk("r0_pc", PC, 32'd0);
        rv_lat = 3;
        @(negedge clk);
        decodeReady = 1'b0;
        @(negedge clk);
        chk("wait_req_low", {31'd0, imemReq}, 32'd0);
        chk("wait_count", instCount, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_valid", {31'd0, instValid}, 32'd0);
        chk("rstw_pc", PC, RESET_PC);
        chk("rstw_count", instCount, 32'd0);
        rst = 1'b0;
        rv_lat = 0;

        // reset in HOLD
        decodeReady = 1'b1;
        wait_valid("h0");
        chk("h0_pc", PC, 32'd0);
        @(negedge clk);
        decodeReady = 1'b0;
        wait_valid("h4");
        chk("h4_pc", PC, 32'd4);
        chk("h4_count", instCount, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rsth_valid", {31'd0, instValid}, 32'd0);
        chk("rsth_pc", PC, RESET_PC);
        chk("rsth_count", instCount, 32'd0);
        rst = 1'b0;
        wait_valid("restart");
        chk("restart_pc", PC, RESET_PC);
        chk("restart_inst", inst, 32'h0050_0093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
